// File: rtl/modmult_sm_if.sv
// Start/busy/done handshake and operand bus for the sequential (modular) multiplier.
interface modmult_sm_if #(parameter int W = 32);
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] m;
  logic         busy;
  logic         done;
  logic         err;
  logic [2*W-1:0] result;

  modport master (output start, mode, a, b, m, input busy, done, err, result);
  modport slave  (input start, mode, a, b, m, output busy, done, err, result);
endinterface

// File: rtl/modmult_sm.sv
// Bit-serial multiplier / Blakley modular multiplier: a consumed MSB first,
// one bit per cycle, with at most two conditional subtractions per step in mode 1.
module modmult_sm #(
  parameter int W = 32
) (
  input logic         clk,
  input logic         reset,
  modmult_sm_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t         state;
  logic           mode_q;
  logic [W-1:0]   a_q, b_q, m_q;
  logic [2*W-1:0] r_q;
  logic [CW-1:0]  cnt_q;

  logic [W-1:0]   addend;
  logic [W+1:0]   t0, t1, t2;
  logic [2*W-1:0] r_plain, r_mod, r_next;

  // a_q is shifted left each step, so its MSB is always the current multiplier bit.
  always_comb begin
    addend  = a_q[W-1] ? b_q : '0;
    r_plain = (r_q << 1) + {{W{1'b0}}, addend};
    // 2R + b < 3m since R < m and b < m, so two subtractions bring T back below m.
    t0      = {1'b0, r_q[W-1:0], 1'b0} + {2'b00, addend};
    t1      = (t0 >= {2'b00, m_q}) ? t0 - {2'b00, m_q} : t0;
    t2      = (t1 >= {2'b00, m_q}) ? t1 - {2'b00, m_q} : t1;
    r_mod   = (2*W)'(t2);
    r_next  = mode_q ? r_mod : r_plain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q     <= bus.mode;
            a_q        <= bus.a;
            b_q        <= bus.b;
            m_q        <= bus.m;
            r_q        <= '0;
            cnt_q      <= '0;
            bus.busy   <= 1'b1;
            bus.result <= '0;
            if (bus.mode && (bus.m == '0 || bus.b >= bus.m)) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.err  <= 1'b0;
              state    <= ITER;
            end
          end
        end
        ITER: begin
          r_q   <= r_next;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            bus.done   <= 1'b1;
            bus.result <= r_next;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modmult_sm.sv
// Bench for modmult_sm at W = 8, 16 and 32: cycle-level behavioural model per
// instance, checked every cycle, plus directed literal checks and random ops.
module tb_modmult_sm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic        st [3];
  logic        md [3];
  logic [31:0] ta [3];
  logic [31:0] tb_ [3];
  logic [31:0] tm [3];
  logic        o_busy [3];
  logic        o_done [3];
  logic        o_err  [3];
  logic [63:0] o_res  [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 32;
    modmult_sm_if #(.W(W)) bus ();
    modmult_sm #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.start = st[g];
    assign bus.mode  = md[g];
    assign bus.a     = ta[g][W-1:0];
    assign bus.b     = tb_[g][W-1:0];
    assign bus.m     = tm[g][W-1:0];
    assign o_busy[g] = bus.busy;
    assign o_done[g] = bus.done;
    assign o_err[g]  = bus.err;
    assign o_res[g]  = 64'(bus.result);

    // Model: cycles left in the busy window; the answer appears when one remains.
    int          left = 0;
    logic [63:0] e_res = '0, pend = '0;
    logic        e_err = 1'b0, perr = 1'b0;
    logic [63:0] av, bv, mv;

    always @(posedge clk) begin
      if (reset) begin
        left = 0; e_res = '0; e_err = 1'b0;
      end else if (left == 0) begin
        if (bus.start) begin
          av = 64'(bus.a); bv = 64'(bus.b); mv = 64'(bus.m);
          perr = bus.mode && (mv == 0 || bv >= mv);
          if (perr)          pend = '0;
          else if (bus.mode) pend = (av * bv) % mv;
          else               pend = av * bv;
          left  = perr ? 1 : W + 1;
          e_res = '0;
          e_err = 1'b0;
        end
      end else begin
        left--;
      end
      if (left == 1) begin
        e_res = pend;
        e_err = perr;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("w%0d_busy", W), 64'(bus.busy), 64'(left > 0));
        chk($sformatf("w%0d_done", W), 64'(bus.done), 64'(left == 1));
        chk($sformatf("w%0d_err", W), 64'(bus.err), 64'(e_err));
        chk($sformatf("w%0d_result", W), 64'(bus.result), e_res);
      end
    end
  end

  // Called on a negedge; start is high for exactly one cycle (cycle 0).
  task automatic start_op(input int k, input logic mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] m);
    st[k] = 1'b1; md[k] = mode; ta[k] = a; tb_[k] = b; tm[k] = m;
    @(negedge clk);
    st[k] = 1'b0; md[k] = 1'($urandom); ta[k] = $urandom; tb_[k] = $urandom; tm[k] = $urandom;
  endtask

  // Entered mid cycle 1; leaves mid cycle after DONE (IDLE again).
  task automatic wait_done(input int k, output int c, output logic [63:0] r, output logic e);
    c = 1;
    while (!o_done[k] && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!o_done[k]) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: unit %0d got no done after %0d cycles, required done", k, c);
    end
    r = o_res[k];
    e = o_err[k];
    @(negedge clk);
  endtask

  task automatic op_check(input int k, input string nm, input logic mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] m, input logic [63:0] exp_r,
                          input logic exp_e, input int exp_c);
    int c; logic [63:0] r; logic e;
    start_op(k, mode, a, b, m);
    wait_done(k, c, r, e);
    chk({nm, "_res"}, r, exp_r);
    chk({nm, "_err"}, 64'(e), 64'(exp_e));
    chk({nm, "_cyc"}, 64'(c), 64'(exp_c));
  endtask

  task automatic rand_run(input int k, input int n);
    int w; int c; logic [63:0] r; logic e; logic [31:0] mask, a, b, m;
    w = (k == 0) ? 8 : (k == 1) ? 16 : 32;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < n; i++) begin
        a = $urandom & mask;
        m = $urandom & mask;
        if ($urandom_range(0, 15) != 0) begin
          if (m == 0) m = 1;
          b = ($urandom & mask) % m;
        end else begin
          b = $urandom & mask;
        end
        start_op(k, 1'(mode), a, b, m);
        wait_done(k, c, r, e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; md[k] = 1'b0; ta[k] = '0; tb_[k] = '0; tm[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 64'(o_busy[k]), 64'd0);
      chk("rst_done", 64'(o_done[k]), 64'd0);
      chk("rst_err", 64'(o_err[k]), 64'd0);
      chk("rst_result", o_res[k], 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    op_check(0, "mod_basic", 1'b1, 32'h0F, 32'h0B, 32'h11, 64'h000C, 1'b0, 9);
    op_check(0, "mul_ff",    1'b0, 32'hFF, 32'hFF, 32'h00, 64'hFE01, 1'b0, 9);
    op_check(0, "mul_zero",  1'b0, 32'h00, 32'hFF, 32'h00, 64'h0000, 1'b0, 9);
    op_check(0, "err_m0",    1'b1, 32'h05, 32'h03, 32'h00, 64'h0000, 1'b1, 1);
    op_check(0, "err_bge",   1'b1, 32'h05, 32'h12, 32'h11, 64'h0000, 1'b1, 1);
    op_check(0, "clr_err",   1'b1, 32'h03, 32'h05, 32'h07, 64'h0001, 1'b0, 9);
    op_check(2, "w32_zero",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'd0, 1'b0, 33);
    op_check(2, "w32_one",   1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'd1, 1'b0, 33);

    // Starts at cycles 3 (ITER) and 9 (DONE) must be ignored.
    st[0] = 1'b1; md[0] = 1'b1; ta[0] = 32'h0F; tb_[0] = 32'h0B; tm[0] = 32'h11;
    @(negedge clk); st[0] = 1'b0;
    repeat (2) @(negedge clk);
    st[0] = 1'b1; md[0] = 1'b0; ta[0] = 32'hFF; tb_[0] = 32'hFF;
    @(negedge clk); st[0] = 1'b0;
    repeat (5) @(negedge clk);
    st[0] = 1'b1; ta[0] = 32'h77; tb_[0] = 32'h99;
    chk("busy_start_done", 64'(o_done[0]), 64'd1);
    chk("busy_start_res", o_res[0], 64'h000C);
    @(negedge clk); st[0] = 1'b0;
    chk("busy_start_idle", 64'(o_busy[0]), 64'd0);
    @(negedge clk);
    chk("busy_start_noq", 64'(o_busy[0]), 64'd0);

    // Reset in cycle 4 aborts the operation.
    start_op(0, 1'b0, 32'hFF, 32'hFF, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(o_busy[0]), 64'd0);
    chk("abort_done", 64'(o_done[0]), 64'd0);
    chk("abort_res", o_res[0], 64'd0);
    reset = 1'b0;
    @(negedge clk);
    op_check(0, "post_rst", 1'b0, 32'h12, 32'h34, 32'h0, 64'h03A8, 1'b0, 9);

    // Reset wins over a simultaneous start.
    reset = 1'b1; st[0] = 1'b1; md[0] = 1'b0; ta[0] = 32'h5; tb_[0] = 32'h6;
    @(negedge clk);
    reset = 1'b0; st[0] = 1'b0;
    chk("rst_start_busy", 64'(o_busy[0]), 64'd0);
    @(negedge clk);
    chk("rst_start_idle", 64'(o_busy[0]), 64'd0);

    // Start held high: back-to-back operations every W+2 cycles.
    c1 = 0; c2 = 0;
    st[0] = 1'b1; md[0] = 1'b0; ta[0] = 32'h03; tb_[0] = 32'h05;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (o_done[0] && c1 == 0) c1 = c;
      else if (o_done[0] && c2 == 0) c2 = c;
    end
    @(negedge clk); st[0] = 1'b0;
    chk("b2b_first", 64'(c1), 64'd9);
    chk("b2b_second", 64'(c2), 64'd19);
    chk("b2b_res", o_res[0], 64'h000F);
    repeat (2) @(negedge clk);

    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
    join
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/modmult_sm.md
# modmult_sm

Parametrised sequential multiplier and modular multiplier for the RSA datapath. It computes either the full product a*b or (a*b) mod m using MSB-first interleaved shift-add reduction (Blakley), one multiplier bit per cycle. It sits under the modular-exponentiation controller, which uses it for every square and multiply step. It handles arbitrary operand width, modular reduction, operand-error detection and a start/busy/done handshake.

## Interface
- W, default 32: operand width in bits; must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- mode  in  1  0 = plain product, 1 = modular product; captured with start.
- a  in  W  multiplier; bits are consumed MSB first; captured with start.
- b  in  W  multiplicand; captured with start.
- m  in  W  modulus, used when mode = 1; captured with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; result and err are valid in that cycle.
- err  out  1  operand error for the last operation; held with result.
- result  out  2W  mode 0: full product; mode 1: residue in bits [W-1:0] with bits [2W-1:W] = 0.

## Operation
- State machine: IDLE, ITER, DONE.
- IDLE:
  - If start = 1, capture a, b, m and mode into internal registers, clear accumulator R and bit counter, then go to ITER.
  - Error check at capture, applies only when mode = 1: if m == 0 or b ≥ m, set err = 1 and go directly to DONE. Result is then 0.
- ITER, for i = W-1 down to 0, one bit per cycle:
  - mode 0: R ← 2R + (a[i] ? b : 0). R is 2W bits wide and cannot overflow.
  - mode 1: T ← 2R + (a[i] ? b : 0). This uses W+2-bit arithmetic, and T < 3m holds.
  - mode 1 reduction: if T ≥ m then T ← T − m; if T ≥ m again then T ← T − m; then R ← T. Invariant R < m.
  - After the iteration with i = 0, go to DONE.
- DONE: drive done = 1 and load result from R (or 0 on error). Return to IDLE the next cycle.
- result and err hold their values until the next start is accepted; both are cleared on acceptance.
- Inputs a, b, m and mode may change freely after capture without affecting the operation in flight.
- a is unrestricted: a ≥ m is legal in mode 1.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, result 0, internal registers 0.
- Reset asserted mid-operation aborts it. At the next edge: IDLE, no done pulse, result 0.
- Let start be high in cycle 0 while in IDLE:
  - ITER occupies cycles 1..W.
  - DONE is cycle W+1, with done = 1 and result valid.
  - IDLE resumes in cycle W+2, so the earliest next start is cycle W+2.
  - Latency from start to done is W+1 cycles.
- Error path: DONE in cycle 1, with done = 1, err = 1 and result 0.
- start while busy = 1 is ignored, including in the DONE cycle. It is neither queued nor does it corrupt the operation.
- start held continuously produces back-to-back operations every W+2 cycles.
- Reset and start asserted in the same cycle: reset wins and the operation is not accepted.

## Test plan
- W=8, mode 1, a=0x0F, b=0x0B, m=0x11 -> done in cycle 9, result=0x000C, err=0. busy is high in cycles 1-9.
- W=8, mode 0, a=0xFF, b=0xFF -> result=0xFE01, err=0. Also a=0x00, b=0xFF -> result=0x0000.
- W=8, mode 1, m=0x00 (and separately b=0x12, m=0x11) -> done in cycle 1, err=1, result=0. The next valid op clears err.
- W=32, mode 1, a=0xFFFFFFFF, b=0xFFFFFFFE, m=0xFFFFFFFF -> result=0. Also a=0xFFFFFFFE, b=0xFFFFFFFE, m=0xFFFFFFFF -> result=1.
- W=8, start pulsed again at cycles 3 and 9 with different operands -> first result unchanged; the new op is accepted only after a start in IDLE.
- Reset at cycle 4 of an op -> cycle 5 in IDLE, busy=0, result=0, no done pulse. A fresh op afterwards completes correctly.
- Random self-check, W=8 and W=16, 1000 ops per mode -> matches the a*b and (a*b) mod m reference model.
